// File: rtl/video_mixer_pkg.sv
// Shared widths, the colour-expansion rule and the scanline period table
// for the video_mixer_sl output stage.
package video_mixer_pkg;

    localparam int OUT_W = 8;
    localparam int LVL_W = 4;
    localparam int LAT   = 2;

    typedef struct packed {
        logic [OUT_W-1:0] r;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] b;
    } rgb_t;

    // Widen a cw-bit value held in c[cw-1:0] by repeating its MSBs into the low bits.
    function automatic logic [OUT_W-1:0] expand_cw(input logic [OUT_W-1:0] c, input int cw);
        logic [OUT_W-1:0] res;
        logic [2:0]       src;
        logic [2:0]       dst;
        res = '0;
        for (int i = 0; i < OUT_W; i++) begin
            src      = 3'(cw - 1 - (i % cw));
            dst      = 3'(OUT_W - 1 - i);
            res[dst] = c[src];
        end
        return res;
    endfunction

    function automatic logic [2:0] period_n(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/video_mixer_sl_dimmer.sv
// Output stage for one colour component: registered scanline attenuation
// with a blanking override.
module scanline_dimmer
    import video_mixer_pkg::*;
(
    input  logic             clk_vid,
    input  logic             reset,
    input  logic [OUT_W-1:0] c8_in,
    input  logic             dim,
    input  logic [LVL_W-1:0] lvl,
    input  logic             blank,
    output logic [OUT_W-1:0] c_out
);

    logic [OUT_W-1:0] scaled;
    logic [OUT_W-1:0] c_d;
    logic [OUT_W-1:0] c_q;

    // 8x5 product never exceeds 12 bits, so >>4 then truncation keeps bits [11:4].
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        scaled = 8'((13'(c8_in) * 13'(5'd16 - 5'(lvl))) >> 4);
        c_d    = c8_in;
        if (blank) begin
            c_d = '0;
        end else if (dim) begin
            c_d = scaled;
        end
    end

    always_ff @(posedge clk_vid) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c_out = c_q;

endmodule

// File: rtl/video_mixer_sl.sv
// Output mixer: colour expansion, S1 capture, frame-latched scanline config,
// line counter and DE generation; S2 lives in the dimmers and timing flops.
module video_mixer_sl
    import video_mixer_pkg::*;
#(
    parameter int CW      = 8,
    parameter bit MONO_EN = 1'b1
) (
    input  logic          clk_vid,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          mono,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic          field,
    input  logic [3:0]    sl_level,
    input  logic [1:0]    sl_period,
    input  logic          blank_black,
    output logic          ce_pix_out,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE
);

    rgb_t c8;

    generate
        if (CW == 4 && MONO_EN) begin : g_mono
            always_comb begin
                c8.r = expand_cw(8'(R), CW);
                c8.g = expand_cw(8'(G), CW);
                c8.b = expand_cw(8'(B), CW);
                if (mono) begin
                    c8 = '{r: {G, R}, g: {G, R}, b: {G, R}};
                end
            end
        end else begin : g_color
            logic unused_mono;
            assign unused_mono = mono;
            assign c8 = '{r: expand_cw(8'(R), CW), g: expand_cw(8'(G), CW), b: expand_cw(8'(B), CW)};
        end
    endgenerate

    rgb_t             c_s1_q;
    logic             hs_s1_q, vs_s1_q, ce_s1_q, hde_s1_q, bb_s1_q;
    logic             dim_s1_q, dim_d;
    logic             de_q, de_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [1:0]       per_q, per_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       cnt_last;
    logic             hde, hs_fall, vs_fall;

    always_comb begin
        hde      = ~HBlank;
        hs_fall  = hs_s1_q & ~HSync;
        vs_fall  = vs_s1_q & ~VSync;
        cnt_last = 2'(period_n(per_q) - 3'd1);
        lvl_d    = lvl_q;
        per_d    = per_q;
        cnt_d    = cnt_q;
        de_d     = de_q;

        // Every period has N >= 2, so the field phase 0/1 is already reduced modulo N.
        if (vs_fall) begin
            lvl_d = sl_level;
            per_d = sl_period;
            cnt_d = field ? 2'd1 : 2'd0;
        end else if (hs_fall) begin
            cnt_d = (cnt_q == cnt_last) ? 2'd0 : cnt_q + 2'd1;
        end

        if (~hde_s1_q & hde) begin
            de_d = ~VBlank;
        end else if (hde_s1_q & ~hde) begin
            de_d = 1'b0;
        end

        dim_d = (cnt_q == cnt_last) && (lvl_q != '0);
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            c_s1_q   <= '0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            ce_s1_q  <= 1'b0;
            hde_s1_q <= 1'b0;
            bb_s1_q  <= 1'b0;
            dim_s1_q <= 1'b0;
            de_q     <= 1'b0;
            lvl_q    <= '0;
            per_q    <= '0;
            cnt_q    <= '0;
        end else begin
            c_s1_q   <= c8;
            hs_s1_q  <= HSync;
            vs_s1_q  <= VSync;
            ce_s1_q  <= ce_pix;
            hde_s1_q <= hde;
            bb_s1_q  <= blank_black;
            dim_s1_q <= dim_d;
            de_q     <= de_d;
            lvl_q    <= lvl_d;
            per_q    <= per_d;
            cnt_q    <= cnt_d;
        end
    end

    logic blank;
    assign blank = bb_s1_q & ~de_q;

    scanline_dimmer u_dim_r (
        .clk_vid (clk_vid), .reset (reset), .c8_in (c_s1_q.r), .dim (dim_s1_q),
        .lvl (lvl_q), .blank (blank), .c_out (VGA_R)
    );
    scanline_dimmer u_dim_g (
        .clk_vid (clk_vid), .reset (reset), .c8_in (c_s1_q.g), .dim (dim_s1_q),
        .lvl (lvl_q), .blank (blank), .c_out (VGA_G)
    );
    scanline_dimmer u_dim_b (
        .clk_vid (clk_vid), .reset (reset), .c8_in (c_s1_q.b), .dim (dim_s1_q),
        .lvl (lvl_q), .blank (blank), .c_out (VGA_B)
    );

    logic hs_s2_q, vs_s2_q, de_s2_q, ce_s2_q;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            hs_s2_q <= 1'b0;
            vs_s2_q <= 1'b0;
            de_s2_q <= 1'b0;
            ce_s2_q <= 1'b0;
        end else begin
            hs_s2_q <= hs_s1_q;
            vs_s2_q <= vs_s1_q;
            de_s2_q <= de_q;
            ce_s2_q <= ce_s1_q;
        end
    end

    assign VGA_HS     = hs_s2_q;
    assign VGA_VS     = vs_s2_q;
    assign VGA_DE     = de_s2_q;
    assign ce_pix_out = ce_s2_q;

endmodule

// File: tb/tb_video_mixer_sl.sv
// Directed bench for video_mixer_sl: an 8-bit and a 4-bit/mono instance share
// timing inputs; expectations queue at drive time and retire LAT cycles later.
module tb_video_mixer_sl;
    import video_mixer_pkg::*;

    logic       clk_vid = 1'b0;
    logic       reset;
    logic       ce_pix, mono, HSync, VSync, HBlank, VBlank, field, blank_black;
    logic [7:0] R, G, B;
    logic [3:0] R4, G4, B4;
    logic [3:0] sl_level;
    logic [1:0] sl_period;

    logic       ce8, hs8, vs8, de8;
    logic [7:0] r8o, g8o, b8o;
    logic       ce4, hs4, vs4, de4;
    logic [7:0] r4o, g4o, b4o;

    always #5 clk_vid = ~clk_vid;

    video_mixer_sl #(.CW(8), .MONO_EN(1'b1)) dut8 (
        .clk_vid (clk_vid), .reset (reset), .ce_pix (ce_pix),
        .R (R), .G (G), .B (B), .mono (mono),
        .HSync (HSync), .VSync (VSync), .HBlank (HBlank), .VBlank (VBlank),
        .field (field), .sl_level (sl_level), .sl_period (sl_period),
        .blank_black (blank_black), .ce_pix_out (ce8),
        .VGA_R (r8o), .VGA_G (g8o), .VGA_B (b8o),
        .VGA_HS (hs8), .VGA_VS (vs8), .VGA_DE (de8)
    );

    video_mixer_sl #(.CW(4), .MONO_EN(1'b1)) dut4 (
        .clk_vid (clk_vid), .reset (reset), .ce_pix (ce_pix),
        .R (R4), .G (G4), .B (B4), .mono (mono),
        .HSync (HSync), .VSync (VSync), .HBlank (HBlank), .VBlank (VBlank),
        .field (field), .sl_level (sl_level), .sl_period (sl_period),
        .blank_black (blank_black), .ce_pix_out (ce4),
        .VGA_R (r4o), .VGA_G (g4o), .VGA_B (b4o),
        .VGA_HS (hs4), .VGA_VS (vs4), .VGA_DE (de4)
    );

    typedef struct {
        bit         c8;
        logic [7:0] r, g, b;
        logic       hs, vs, ce, de;
        bit         c4;
        logic [7:0] r4, g4, b4;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic       exp_de   = 1'b0;
    bit         chk4     = 1'b0;
    logic [7:0] exp4_r, exp4_g, exp4_b;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " R"},  r8o, 8'h00);
        check({tag, " G"},  g8o, 8'h00);
        check({tag, " B"},  b8o, 8'h00);
        check({tag, " HS"}, {7'b0, hs8}, 8'h00);
        check({tag, " VS"}, {7'b0, vs8}, 8'h00);
        check({tag, " DE"}, {7'b0, de8}, 8'h00);
        check({tag, " CE"}, {7'b0, ce8}, 8'h00);
        check({tag, " R4"}, r4o, 8'h00);
        check({tag, " G4"}, g4o, 8'h00);
        check({tag, " B4"}, b4o, 8'h00);
    endtask

    // Queue this cycle's expectation, clock once, retire the entry that is LAT cycles old.
    task automatic tick(input bit c8, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        exp_t e;
        e.c8 = c8;  e.r = er;  e.g = eg;  e.b = eb;
        e.hs = HSync;  e.vs = VSync;  e.ce = ce_pix;  e.de = exp_de;
        e.c4 = chk4;  e.r4 = exp4_r;  e.g4 = exp4_g;  e.b4 = exp4_b;
        sb.push_back(e);
        @(posedge clk_vid);
        #1;
        if (sb.size() == LAT) begin
            e = sb.pop_front();
            check("HS", {7'b0, hs8}, {7'b0, e.hs});
            check("VS", {7'b0, vs8}, {7'b0, e.vs});
            check("CE", {7'b0, ce8}, {7'b0, e.ce});
            check("DE", {7'b0, de8}, {7'b0, e.de});
            if (e.c8) begin
                check("R", r8o, e.r);
                check("G", g8o, e.g);
                check("B", b8o, e.b);
            end
            if (e.c4) begin
                check("R4", r4o, e.r4);
                check("G4", g4o, e.g4);
                check("B4", b4o, e.b4);
            end
        end
    endtask

    task automatic pixels(input int n, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        repeat (n) tick(1'b1, er, eg, eb);
    endtask

    task automatic hpulse();
        HSync = 1'b1;
        tick(1'b0, 8'h00, 8'h00, 8'h00);
        HSync = 1'b0;
        tick(1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic vpulse(input bit with_hs);
        VSync = 1'b1;
        HSync = with_hs;
        tick(1'b0, 8'h00, 8'h00, 8'h00);
        VSync = 1'b0;
        HSync = 1'b0;
        tick(1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        // Reset with every input active so zero outputs mean something.
        reset = 1'b1;  ce_pix = 1'b1;  mono = 1'b1;
        HSync = 1'b1;  VSync = 1'b1;  HBlank = 1'b0;  VBlank = 1'b0;
        field = 1'b1;  sl_level = 4'hF;  sl_period = 2'd3;  blank_black = 1'b0;
        R = 8'hFF;  G = 8'hFF;  B = 8'hFF;  R4 = 4'hF;  G4 = 4'hF;  B4 = 4'hF;
        exp4_r = 8'h00;  exp4_g = 8'h00;  exp4_b = 8'h00;
        repeat (3) @(posedge clk_vid);
        #1;
        check_reset("reset");

        // Latency and 4-bit expansion.
        reset = 1'b0;  ce_pix = 1'b0;  mono = 1'b0;
        HSync = 1'b0;  VSync = 1'b0;  HBlank = 1'b1;  VBlank = 1'b1;
        field = 1'b0;  sl_level = 4'h0;  sl_period = 2'd0;
        R = 8'h5A;  G = 8'h11;  B = 8'h22;  R4 = 4'hA;  G4 = 4'h5;  B4 = 4'h3;
        chk4 = 1'b1;  exp4_r = 8'hAA;  exp4_g = 8'h55;  exp4_b = 8'h33;
        tick(1'b1, 8'h5A, 8'h11, 8'h22);
        HSync = 1'b1;  ce_pix = 1'b1;
        tick(1'b1, 8'h5A, 8'h11, 8'h22);
        HSync = 1'b0;  ce_pix = 1'b0;
        tick(1'b1, 8'h5A, 8'h11, 8'h22);

        // Mono on the 4-bit instance; the 8-bit instance ignores it.
        mono = 1'b1;  R = 8'hC3;  R4 = 4'hC;  G4 = 4'h3;  B4 = 4'h9;
        exp4_r = 8'h3C;  exp4_g = 8'h3C;  exp4_b = 8'h3C;
        pixels(2, 8'hC3, 8'h11, 8'h22);
        chk4 = 1'b0;  mono = 1'b0;

        // Dimming math, period 2, field 0.
        R = 8'hFF;  G = 8'h80;  B = 8'h33;  sl_level = 4'd8;
        vpulse(1'b0);
        pixels(3, 8'hFF, 8'h80, 8'h33);
        hpulse();
        pixels(3, 8'h7F, 8'h40, 8'h19);
        hpulse();
        pixels(3, 8'hFF, 8'h80, 8'h33);
        sl_level = 4'd15;
        vpulse(1'b0);
        hpulse();
        pixels(3, 8'h0F, 8'h08, 8'h03);

        // Shadow config: a mid-frame level change waits for the next frame.
        sl_level = 4'd8;
        vpulse(1'b0);
        pixels(2, 8'hFF, 8'h80, 8'h33);
        sl_level = 4'd4;
        hpulse();
        pixels(2, 8'h7F, 8'h40, 8'h19);
        hpulse();
        pixels(2, 8'hFF, 8'h80, 8'h33);
        vpulse(1'b0);
        hpulse();
        pixels(2, 8'hBF, 8'h60, 8'h26);

        // Period 3 with field 1: lines 1, 4, 7 dimmed.
        sl_level = 4'd8;  sl_period = 2'd1;  field = 1'b1;
        vpulse(1'b0);
        for (int ln = 0; ln < 10; ln++) begin
            if (ln > 0) hpulse();
            if (ln % 3 == 1) pixels(2, 8'h7F, 8'h40, 8'h19);
            else             pixels(2, 8'hFF, 8'h80, 8'h33);
        end
        // Counter sits at 1; a simultaneous HS/VS fall must reload, not advance.
        vpulse(1'b1);
        pixels(2, 8'hFF, 8'h80, 8'h33);
        hpulse();
        pixels(2, 8'h7F, 8'h40, 8'h19);

        // Code 3 maps to a 4-line period.
        sl_period = 2'd3;  field = 1'b0;
        vpulse(1'b0);
        for (int ln = 0; ln < 5; ln++) begin
            if (ln > 0) hpulse();
            if (ln == 3) pixels(1, 8'h7F, 8'h40, 8'h19);
            else         pixels(1, 8'hFF, 8'h80, 8'h33);
        end

        // DE generation and blank_black.
        sl_level = 4'd0;
        vpulse(1'b0);
        blank_black = 1'b1;
        HBlank = 1'b0;
        pixels(3, 8'h00, 8'h00, 8'h00);
        HBlank = 1'b1;
        pixels(1, 8'h00, 8'h00, 8'h00);
        VBlank = 1'b0;
        pixels(1, 8'h00, 8'h00, 8'h00);
        HBlank = 1'b0;  exp_de = 1'b1;
        pixels(3, 8'hFF, 8'h80, 8'h33);
        VBlank = 1'b1;
        pixels(2, 8'hFF, 8'h80, 8'h33);
        HBlank = 1'b1;  exp_de = 1'b0;
        pixels(2, 8'h00, 8'h00, 8'h00);
        blank_black = 1'b0;
        pixels(1, 8'hFF, 8'h80, 8'h33);
        HBlank = 1'b0;
        pixels(2, 8'hFF, 8'h80, 8'h33);

        // Reset mid-line clears outputs on the very next edge.
        reset = 1'b1;  HSync = 1'b1;  VSync = 1'b1;  ce_pix = 1'b1;
        @(posedge clk_vid);
        #1;
        check_reset("midreset");
        sb.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/video_mixer_sl.md
Name: video_mixer_sl

Overview:
- Parametrised next-generation output mixer; sits between the core's native video (or scandoubler output) and the sys-level VGA path.
- Expands CW-bit colour to 8 bits, optionally in monochrome.
- Applies programmable scanline dimming with 16 attenuation levels, selectable line period and interlace field phase.
- Generates a clean DE, optionally blacks out blanking, and aligns every output to a fixed 2-cycle latency.

Parameters:
- CW, 8, input colour width per component; legal range 4..8.
- MONO_EN, 1, enables the mono input path; only meaningful when CW==4.

Ports:
- clk_vid  in  1  video clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; passed through, not used for gating.
- R, G, B  in  CW each  input colour.
- mono  in  1  CW==4 and MONO_EN: all components = {G,R}.
- HSync, VSync, HBlank, VBlank  in  1 each  positive-pulse timing.
- field  in  1  interlace field; sets the scanline start phase.
- sl_level  in  4  dimming: 0 = off, 15 = maximum.
- sl_period  in  2  dim one line of every N; N = 2, 3, 4, 4 for codes 0..3.
- blank_black  in  1  force RGB to 0 whenever output DE is 0.
- ce_pix_out  out  1  ce_pix delayed 2 cycles.
- VGA_R, VGA_G, VGA_B  out  8 each  output colour.
- VGA_HS, VGA_VS, VGA_DE  out  1 each  output timing.

Behaviour:
- Reset: every output 0; pipeline registers, line counter and shadow config registers all 0. Reset applied mid-line takes effect the next cycle. The first VS falling edge after reset establishes phase.
- Pipeline: stage S1 registers inputs; stage S2 drives outputs. Latency is exactly 2 clk_vid cycles for RGB, HS, VS, DE and ce_pix_out. No stalls; a new pixel is accepted every cycle.

Colour expansion (combinational, before S1):
- CW==8: identity.
- CW<8: c8 = {c, c[CW-1 -: 8-CW]} (MSB replication).
- Mono (CW==4, MONO_EN, mono=1): c8 = {G,R} for all three components.

Edge detection:
- Compares S1-registered signals with the current inputs.
- hs_fall = hs_s1 & ~HSync; vs_fall = vs_s1 & ~VSync.

Shadow config:
- sl_level and sl_period are latched into lvl_q and per_q only on vs_fall. Mid-frame changes are ignored until the next frame.

Line counter cnt (2 bits):
- vs_fall: cnt <= field ? 1 : 0, computed modulo N of the newly latched per_q. This has priority over a simultaneous hs_fall.
- hs_fall otherwise: cnt <= (cnt == N-1) ? 0 : cnt+1.

Dimming:
- Dim flag in S1 = (cnt == N-1) & (lvl_q != 0).
- S2 colour = dim ? (c8 * (16 - lvl_q)) >> 4 : c8.
- Product is 8x5 unsigned = 13 bits; take bits [11:4]. No overflow is possible; level 0 is exact.

DE:
- S1 de register: hde = ~HBlank, vde = ~VBlank.
  - Rising hde (~hde_s1 & hde): de <= vde.
  - Falling hde: de <= 0.
  - Otherwise de holds.
- VGA_DE <= de in S2. A VBlank change mid-line does not alter DE until the next hde rise.

Blanking:
- blank_black=1 and S1 de==0: S2 RGB = 0, overriding dimming.

Passthrough:
- VGA_HS and VGA_VS are the inputs delayed 2 cycles.

Decomposition:
- Package video_mixer_pkg:
  - localparam OUT_W=8, LVL_W=4, LAT=2.
  - function expand_cw(c, cw) for the replication rule.
  - function period_n(code) mapping codes 0..3 to 2, 3, 4, 4.
- Sub-module scanline_dimmer, instantiated 3x:
  - Ports: clk_vid, reset, c8_in[7:0], dim, lvl[3:0], blank, c_out[7:0].
  - Performs the one-stage (S2) registered multiply/shift and blank override.
- Top level owns expansion, S1 registers, edge detect, shadow config, counter and DE.

Test Plan:
1. Latency: reset, CW=8, sl_level=0, R=0x5A, one-cycle HSync pulse → VGA_R=0x5A and VGA_HS=1 exactly 2 cycles later; all outputs 0 during reset.
2. Expansion: CW=4, R=0xA → VGA_R=0xAA. Then mono=1, G=0x3, R=0xC → VGA_R=VGA_G=VGA_B=0x3C.
3. Dimming math: sl_period=0, sl_level=8 latched at vs_fall, field=0, R=0xFF.
   - Line 0 outputs 0xFF; line 1 outputs 0x7F; line 2 outputs 0xFF.
   - sl_level=15 on a dimmed line → 0x0F.
4. Period and field: sl_period=1, field=1 → cnt starts at 1, so lines 1, 4, 7 (counting from 0) are dimmed. Simultaneous HS and VS falling edges → counter loads field, no increment.
5. Shadow config: change sl_level from 8 to 4 mid-frame → dimmed lines still output 0x7F for R=0xFF until the next vs_fall, then 0xBF.
6. DE and blank: HBlank falls while VBlank=1 → VGA_DE stays 0; with blank_black=1, RGB=0 during blanking. HBlank toggles with VBlank=0 → VGA_DE rises 2 cycles after HBlank falls and drops 2 cycles after HBlank rises.
